// File: rtl/mcs4_pkg.sv
// Shared constants for the MCS-4 clock and machine-cycle sequencer.
// Machine states A1..X3 and the four phase slots of one PHI period.
package mcs4_pkg;

  localparam logic [2:0] STATE_A1 = 3'd0;
  localparam logic [2:0] STATE_A2 = 3'd1;
  localparam logic [2:0] STATE_A3 = 3'd2;
  localparam logic [2:0] STATE_M1 = 3'd3;
  localparam logic [2:0] STATE_M2 = 3'd4;
  localparam logic [2:0] STATE_X1 = 3'd5;
  localparam logic [2:0] STATE_X2 = 3'd6;
  localparam logic [2:0] STATE_X3 = 3'd7;

  typedef enum logic [1:0] {
    SLOT_PHI1 = 2'd0,
    SLOT_GAP1 = 2'd1,
    SLOT_PHI2 = 2'd2,
    SLOT_GAP2 = 2'd3
  } slot_t;

endpackage

// File: rtl/mcs4_reset_stretch.sv
// Holds the CPU reset high for RESET_CYCLES PHI2 rising edges
// after the sequencer leaves asynchronous reset.
module mcs4_reset_stretch #(
  parameter int RESET_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phi2_rise,
  output logic cpu_reset
);

  localparam int CW = $clog2(RESET_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cpu_reset <= 1'b1;
    end else if (cpu_reset && phi2_rise) begin
      if (cnt_q == CW'(RESET_CYCLES - 1))
        cpu_reset <= 1'b0;
      else
        cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mcs4_clock_seq.sv
// Two-phase clock, machine-state and SYNC generator for the MCS-4 core.
// Optional single-step input enabled by MCS4_SINGLE_STEP_EN.
module mcs4_clock_seq
  import mcs4_pkg::*;
#(
  parameter int DIV          = 4,
  parameter int RESET_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       run_i,
`ifdef MCS4_SINGLE_STEP_EN
  input  logic       step_i,
`endif
  output logic       PHI1_o,
  output logic       PHI2_o,
  output logic       SYNC_o,
  output logic       RESET_o,
  output logic [2:0] state_o,
  output logic       cycle_strobe_o,
  output logic       halted_o
);

  localparam int SW = $clog2(DIV + 1);

  slot_t         slot_q, slot_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [2:0]    state_d;
  logic          halted_d;
  logic          step_mode_q, step_mode_d;
  logic          step_rise;
  logic          slot_end;
  logic          at_x3_end;
  logic          phi2_rise;
  logic          strobe_d;
  logic          cpu_reset;

`ifdef MCS4_SINGLE_STEP_EN
  logic [2:0] step_sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      step_sync_q <= '0;
    else
      step_sync_q <= {step_sync_q[1:0], step_i};
  end

  assign step_rise = step_sync_q[1] & ~step_sync_q[2];
`else
  assign step_rise = 1'b0;
`endif

  // sub_q runs 1..DIV inside a slot; 0 only marks the post-reset entry
  assign slot_end  = (sub_q == SW'(DIV));
  assign at_x3_end = (slot_q == SLOT_GAP2) &&
                     (state_o == STATE_X3) && !cpu_reset;

  always_comb begin
    slot_d      = slot_q;
    sub_d       = sub_q;
    halted_d    = halted_o;
    step_mode_d = step_mode_q;
    if (halted_o) begin
      if (run_i || step_rise) begin
        halted_d    = 1'b0;
        step_mode_d = !run_i;
        slot_d      = SLOT_PHI1;
        sub_d       = SW'(1);
      end
    end else if (!slot_end) begin
      sub_d = sub_q + SW'(1);
    end else if (at_x3_end && (!run_i || step_mode_q)) begin
      halted_d    = 1'b1;
      step_mode_d = 1'b0;
    end else begin
      sub_d = SW'(1);
      unique case (slot_q)
        SLOT_PHI1: slot_d = SLOT_GAP1;
        SLOT_GAP1: slot_d = SLOT_PHI2;
        SLOT_PHI2: slot_d = SLOT_GAP2;
        SLOT_GAP2: slot_d = SLOT_PHI1;
      endcase
    end
  end

  always_comb begin
    phi2_rise = (slot_d == SLOT_PHI2) && (slot_q != SLOT_PHI2);
    state_d   = phi2_rise ? state_o + 3'd1 : state_o;
    strobe_d  = phi2_rise && (state_d == STATE_A1) && !cpu_reset;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_q         <= SLOT_PHI1;
      sub_q          <= '0;
      state_o        <= STATE_X3;
      PHI1_o         <= 1'b0;
      PHI2_o         <= 1'b0;
      SYNC_o         <= 1'b0;
      cycle_strobe_o <= 1'b0;
      halted_o       <= 1'b0;
      step_mode_q    <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      sub_q          <= sub_d;
      state_o        <= state_d;
      PHI1_o         <= (slot_d == SLOT_PHI1) && !halted_d;
      PHI2_o         <= (slot_d == SLOT_PHI2) && !halted_d;
      SYNC_o         <= (state_d != STATE_X3);
      cycle_strobe_o <= strobe_d;
      halted_o       <= halted_d;
      step_mode_q    <= step_mode_d;
    end
  end

  mcs4_reset_stretch #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_reset (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .phi2_rise(phi2_rise),
    .cpu_reset(cpu_reset)
  );

  assign RESET_o = cpu_reset;

endmodule

// File: tb/tb_mcs4_clock_seq.sv
// Directed bench for mcs4_clock_seq: DIV=4/64 instance plus a DIV=1/8 one.
// The step test is compiled only when MCS4_SINGLE_STEP_EN is defined.
module tb_mcs4_clock_seq;
  import mcs4_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n2 = 1'b0;
  logic run = 1'b1;
`ifdef MCS4_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  logic       phi1, phi2, sync, cpu_reset, strobe, halted;
  logic [2:0] state;
  logic       f_phi1, f_phi2, f_sync, f_reset, f_strobe, f_halted;
  logic [2:0] f_state;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] RST_VEC = 9'b00_111_0_1_0_0;

  always #5 clk = ~clk;

  mcs4_clock_seq #(.DIV(4), .RESET_CYCLES(64)) u_dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .run_i         (run),
`ifdef MCS4_SINGLE_STEP_EN
    .step_i        (step),
`endif
    .PHI1_o        (phi1),
    .PHI2_o        (phi2),
    .SYNC_o        (sync),
    .RESET_o       (cpu_reset),
    .state_o       (state),
    .cycle_strobe_o(strobe),
    .halted_o      (halted)
  );

  mcs4_clock_seq #(.DIV(1), .RESET_CYCLES(8)) u_fast (
    .clk_i         (clk),
    .rst_n_i       (rst_n2),
    .run_i         (1'b1),
`ifdef MCS4_SINGLE_STEP_EN
    .step_i        (1'b0),
`endif
    .PHI1_o        (f_phi1),
    .PHI2_o        (f_phi2),
    .SYNC_o        (f_sync),
    .RESET_o       (f_reset),
    .state_o       (f_state),
    .cycle_strobe_o(f_strobe),
    .halted_o      (f_halted)
  );

  function automatic logic [8:0] dut_vec();
    return {phi1, phi2, state, sync, cpu_reset, strobe, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] fv;
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    run = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vals got %b want %b", dut_vec(), RST_VEC);
    end
    fv = {f_phi1, f_phi2, f_state, f_sync, f_reset, f_strobe, f_halted};
    checks++;
    if (fv !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vals_fast got %b want %b", fv, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_boot();
    int p, n;
    logic [2:0] st;
    logic [8:0] exp;
    for (int e = 1; e <= 1040; e++) begin
      tick();
      p = (e - 1) % 16;
      n = (e >= 9) ? (e - 9) / 16 + 1 : 0;
      st = 3'((7 + n) % 8);
      exp = {p < 4, p >= 8 && p < 12, st, st != 3'd7, n < 64,
             p == 8 && n % 8 == 1 && n >= 65, 1'b0};
      checks++;
      if (dut_vec() !== exp) begin
        errors++;
        $display("FAIL boot edge %0d got %b want %b", e, dut_vec(), exp);
      end
      checks++;
      if ((phi1 & phi2) !== 1'b0) begin
        errors++;
        $display("FAIL overlap edge %0d got %b want 0", e, phi1 & phi2);
      end
      if (e == 1017) begin
        checks++;
        if ({cpu_reset, state} !== {1'b0, STATE_X3}) begin
          errors++;
          $display("FAIL reset_fall got %b want 0111", {cpu_reset, state});
        end
      end
      if (e == 1033) begin
        checks++;
        if ({strobe, state} !== {1'b1, STATE_A1}) begin
          errors++;
          $display("FAIL first_strobe got %b want 1000", {strobe, state});
        end
      end
    end
  endtask

  task automatic test_halt();
    int guard, p;
    logic [2:0] st;
    logic [8:0] exp;
    guard = 0;
    while (state !== STATE_X1 && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (state !== STATE_X1) begin
      errors++;
      $display("FAIL halt_wait_x1 got %0d want %0d", state, STATE_X1);
    end
    @(negedge clk);
    run = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      p = (8 + k) % 16;
      st = (k < 16) ? 3'd5 : (k < 32) ? 3'd6 : 3'd7;
      exp = {k < 40 && p < 4, k < 40 && p >= 8 && p < 12, st,
             st != 3'd7, 1'b0, 1'b0, k >= 40};
      checks++;
      if (dut_vec() !== exp) begin
        errors++;
        $display("FAIL halt k=%0d got %b want %b", k, dut_vec(), exp);
      end
    end
    @(negedge clk);
    run = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      p = j - 1;
      st = (j >= 9) ? 3'd0 : 3'd7;
      exp = {p < 4, p >= 8 && p < 12, st, st != 3'd7, 1'b0, j == 9, 1'b0};
      checks++;
      if (dut_vec() !== exp) begin
        errors++;
        $display("FAIL resume j=%0d got %b want %b", j, dut_vec(), exp);
      end
    end
  endtask

`ifdef MCS4_SINGLE_STEP_EN
  task automatic test_step();
    int guard, rises, strobes;
    logic prev;
    @(negedge clk);
    run = 1'b0;
    guard = 0;
    while (halted !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL step_wait_halt got %b want 1", halted);
    end
    @(negedge clk);
    step = 1'b1;
    rises = 0;
    strobes = 0;
    prev = phi2;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (phi2 && !prev) rises++;
      if (strobe) strobes++;
      prev = phi2;
      if (i == 2) step = 1'b0;
      if (i == 60) step = 1'b1;
      if (i == 63) step = 1'b0;
    end
    checks++;
    if (rises !== 8) begin
      errors++;
      $display("FAIL step_phi2_edges got %0d want 8", rises);
    end
    checks++;
    if (strobes !== 1) begin
      errors++;
      $display("FAIL step_strobes got %0d want 1", strobes);
    end
    checks++;
    if ({halted, state, phi1, phi2} !== {1'b1, STATE_X3, 2'b00}) begin
      errors++;
      $display("FAIL step_rehalt got %b want 111100",
               {halted, state, phi1, phi2});
    end
    @(negedge clk);
    run = 1'b1;
  endtask
`endif

  task automatic test_midreset();
    int guard;
    guard = 0;
    while (!(state === STATE_M2 && phi2 === 1'b1) && guard < 400) begin
      tick();
      guard++;
    end
    checks++;
    if ({state, phi2} !== {STATE_M2, 1'b1}) begin
      errors++;
      $display("FAIL midrst_wait got %b want 1001", {state, phi2});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL midrst_async got %b want %b", dut_vec(), RST_VEC);
    end
    tick();
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL midrst_held got %b want %b", dut_vec(), RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 1040; e++) begin
      tick();
      if (e == 1) begin
        checks++;
        if ({phi1, phi2, state} !== {2'b10, STATE_X3}) begin
          errors++;
          $display("FAIL midrst_e1 got %b want 10111", {phi1, phi2, state});
        end
      end
      if (e == 9 || e == 1016) begin
        checks++;
        if (cpu_reset !== 1'b1) begin
          errors++;
          $display("FAIL midrst_hold edge %0d got %b want 1", e, cpu_reset);
        end
      end
      if (e == 1017) begin
        checks++;
        if ({cpu_reset, state} !== {1'b0, STATE_X3}) begin
          errors++;
          $display("FAIL midrst_fall got %b want 0111", {cpu_reset, state});
        end
      end
      if (e == 1033) begin
        checks++;
        if ({strobe, state} !== {1'b1, STATE_A1}) begin
          errors++;
          $display("FAIL midrst_strobe got %b want 1000", {strobe, state});
        end
      end
    end
  endtask

  task automatic test_div1();
    int p, n;
    logic [2:0] st;
    logic [8:0] exp, fv;
    @(negedge clk);
    rst_n2 = 1'b1;
    for (int e = 1; e <= 48; e++) begin
      tick();
      p = (e - 1) % 4;
      n = (e >= 3) ? (e - 3) / 4 + 1 : 0;
      st = 3'((7 + n) % 8);
      exp = {p == 0, p == 2, st, st != 3'd7, n < 8,
             p == 2 && n % 8 == 1 && n >= 9, 1'b0};
      fv = {f_phi1, f_phi2, f_state, f_sync, f_reset, f_strobe, f_halted};
      checks++;
      if (fv !== exp) begin
        errors++;
        $display("FAIL div1 edge %0d got %b want %b", e, fv, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_halt();
`ifdef MCS4_SINGLE_STEP_EN
    test_step();
`endif
    test_midreset();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
